rx_frame_sequencer: RTL

Serial-bit receive sequencer sitting between the line input and the receiver's decoding datapath. It hunts for the alternating preamble, locks on the start-frame delimiter (SFD), captures the frame length header, and then gates exactly that many payload bits into the downstream datapath. Frame boundaries are marked with one-cycle pulses, and malformed frames are reported on `Error`. It is the controller that decides when the receive datapath is processing data.

---
 rtl/rx_frame_sequencer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/rx_frame_sequencer.sv
// rx_frame_sequencer: hunts preamble, locks on SFD, captures the length
// header and gates exactly that many payload bits into the receive datapath.
module rx_frame_sequencer #(
    parameter int               PRE_MIN      = 16,
    parameter int               SFD_W        = 8,
    parameter logic [SFD_W-1:0] SFD          = 8'b11010000,
    parameter int               LEN_W        = 12,
    parameter int               MAX_LEN      = 1024,
    parameter int               SYNC_TIMEOUT = 128
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Input,
    input  logic             Abort,
    output logic             DataOut,
    output logic             DataEnable,
    output logic             FrameStart,
    output logic             FrameEnd,
    output logic [LEN_W-1:0] Length,
    output logic             Error
);

    localparam int TO_W  = $clog2(SYNC_TIMEOUT + 1);
    localparam int CNT_W = (LEN_W > TO_W) ? LEN_W : TO_W;
    localparam int TC_W  = $clog2(PRE_MIN + 1);

    localparam logic [TC_W-1:0]  PRE_C    = TC_W'(PRE_MIN);
    localparam logic [TC_W-1:0]  TC_ONE   = TC_W'(1);
    localparam logic [CNT_W-1:0] TO_C     = CNT_W'(SYNC_TIMEOUT);
    localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(LEN_W - 1);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
    localparam logic [LEN_W-1:0] MAX_C    = LEN_W'(MAX_LEN);

    typedef enum logic [1:0] {
        HUNT,
        SYNC,
        HEADER,
        PAYLOAD
    } state_e;

    state_e state_q, state_d;

    logic             prev_q;
    logic [SFD_W-1:0] sr_q, sr_d;
    logic [TC_W-1:0]  tcnt_q, tcnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] shd_q, shd_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             de_q, de_d;
    logic             fs_q, fs_d;
    logic             fe_q, fe_d;
    logic             err_q, err_d;

    logic             trans;
    logic [LEN_W-1:0] shd_nxt;
    logic             len_ok;
    logic             hdr_last;

    assign trans    = (Input != prev_q);
    assign shd_nxt  = {shd_q[LEN_W-2:0], Input};
    assign len_ok   = (shd_nxt != '0) && (shd_nxt <= MAX_C);
    assign hdr_last = (cnt_q == HDR_LAST);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= HUNT;
            prev_q  <= 1'b0;
            sr_q    <= '0;
            tcnt_q  <= '0;
            cnt_q   <= '0;
            shd_q   <= '0;
            len_q   <= '0;
            de_q    <= 1'b0;
            fs_q    <= 1'b0;
            fe_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= Input;
            sr_q    <= sr_d;
            tcnt_q  <= tcnt_d;
            cnt_q   <= cnt_d;
            shd_q   <= shd_d;
            len_q   <= len_d;
            de_q    <= de_d;
            fs_q    <= fs_d;
            fe_q    <= fe_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = {sr_q[SFD_W-2:0], Input};
        tcnt_d  = '0;
        cnt_d   = cnt_q;
        shd_d   = shd_q;
        len_d   = len_q;
        if (Abort) begin
            state_d = HUNT;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                HUNT: begin
                    tcnt_d = trans ? (tcnt_q + TC_ONE) : '0;
                    if (tcnt_d == PRE_C) begin
                        state_d = SYNC;
                        tcnt_d  = '0;
                        cnt_d   = '0;
                    end
                end
                SYNC: begin
                    cnt_d = cnt_q + ONE_C;
                    // A delimiter on the timeout bit still locks
                    if (sr_d == SFD) begin
                        state_d = HEADER;
                        cnt_d   = '0;
                    end else if (cnt_d == TO_C) begin
                        state_d = HUNT;
                        cnt_d   = '0;
                    end
                end
                HEADER: begin
                    shd_d = shd_nxt;
                    cnt_d = cnt_q + ONE_C;
                    if (hdr_last) begin
                        if (len_ok) begin
                            state_d = PAYLOAD;
                            len_d   = shd_nxt;
                            cnt_d   = CNT_W'(shd_nxt);
                        end else begin
                            state_d = HUNT;
                            cnt_d   = '0;
                        end
                    end
                end
                PAYLOAD: begin
                    cnt_d = cnt_q - ONE_C;
                    if (cnt_q == ONE_C) begin
                        state_d = HUNT;
                    end
                end
            endcase
        end
    end

    always_comb begin
        de_d  = (state_d == PAYLOAD);
        fs_d  = 1'b0;
        fe_d  = 1'b0;
        err_d = 1'b0;
        if (Abort) begin
            err_d = (state_q == HEADER) || (state_q == PAYLOAD);
        end else begin
            unique case (state_q)
                HUNT: begin
                    err_d = 1'b0;
                end
                SYNC: begin
                    err_d = (state_d == HUNT);
                end
                HEADER: begin
                    err_d = hdr_last && !len_ok;
                    fs_d  = hdr_last && len_ok;
                end
                PAYLOAD: begin
                    fe_d = (state_d == HUNT);
                end
            endcase
        end
    end

    assign DataOut    = Input & de_q;
    assign DataEnable = de_q;
    assign FrameStart = fs_q;
    assign FrameEnd   = fe_q;
    assign Length     = len_q;
    assign Error      = err_q;

endmodule
